sample_feeder: RTL and testbench
================================

# sample_feeder

Training-sample source that sits directly upstream of the perceptron training controller. It stores up to DEPTH samples (x1, x2, target), loaded through a write port. It replays them one per read request with a fixed two-cycle latency and flags the last sample of the epoch via eof. A rewind pulse, driven from the controller's epoch-restart (initNQ), restarts replay from sample 0 without reloading.

## Interface
- DW, 8, signed width of x1/x2
- DEPTH, 16, max samples stored (power of two)
- AW, 4, log2(DEPTH)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  sync pulse: discard all samples, return to EMPTY
- wr_en  in  1  write one sample
- wr_x1, wr_x2  in  DW  signed sample inputs
- wr_t  in  1  target; 1 means +1, 0 means -1
- wr_last  in  1  qualifies wr_en: this is the final sample of the set
- rewind  in  1  sync pulse: read pointer to 0, eof cleared
- rd_req  in  1  pulse: fetch next sample
- x1, x2  out  DW  registered sample outputs
- t  out  1  registered target
- valid  out  1  outputs hold a fetched sample
- eof  out  1  current outputs are the last stored sample
- ready  out  1  in READY state (set loaded)
- count  out  AW+1  number of stored samples
- err  out  1  sticky: overflow write or read while not READY; cleared by clr or rst

## Operation
- States: EMPTY, LOADING, READY, FETCH.
- EMPTY: wr_en stores at index 0, count=1, goes to LOADING (or READY if wr_last).
- LOADING: each wr_en stores at index count, count++. wr_last with wr_en goes to READY.
- Write with count==DEPTH: dropped, err=1, state unchanged. A wr_last on a dropped write still goes to READY.
- wr_en in READY/FETCH: ignored, err=1.
- READY: rd_req latches rd_ptr, issues a memory read, and goes to FETCH.
- FETCH: lasts one cycle. The x1/x2/t registers load the memory data. eof is set when the fetched index equals count-1. valid=1. rd_ptr advances, wrapping to 0 after count-1. Returns to READY.
- rd_req in FETCH or in EMPTY/LOADING: ignored, err=1.
- rewind in READY or FETCH: rd_ptr=0, eof=0; valid and data are held.
- rewind with rd_req in the same cycle: rewind applies first, so the fetch serves index 0.
- clr: count=0, rd_ptr=0, valid=0, eof=0, err=0, state EMPTY. clr beats every simultaneous input.
- A read past the last sample without rewind wraps to index 0. eof then follows the fetched index.

## Timing
- Reset values: x1=0, x2=0, t=0, valid=0, eof=0, ready=0, count=0, err=0, state EMPTY, rd_ptr=0.
- Read latency: rd_req high in cycle k gives new x1/x2/t/eof visible from cycle k+2. They are stable until the next fetch completes. This fits the controller's reading to waiting to reseting sequence, which loads operands at the end of reseting.
- Memory is synchronous-read: address registered at the edge ending cycle k, data captured into output registers at the edge ending cycle k+1.
- Write path: a sample is stored at the edge where wr_en is sampled. count updates at the same edge.
- ready reflects state combinationally from the state register. It is high in READY and FETCH.
- rst mid-FETCH: everything returns to reset values and memory contents are don't-care. clr mid-FETCH: the fetch is aborted and the outputs are cleared.

## Structure
- Package sample_feeder_pkg: state enum (EMPTY, LOADING, READY, FETCH), default DW/DEPTH/AW constants, sample word layout {t, x2, x1} of width 2*DW+1.
- Sub-module sample_mem: simple dual-port RAM, one write port and one synchronous-read port, width 2*DW+1, depth DEPTH, no reset on the array.
- Top: FSM, count, rd_ptr, output registers, err logic.

## Test plan
- Load (3,-2,1), (-5,4,0), (7,7,1) with wr_last on the third, then three rd_req pulses spaced 4 cycles apart. Outputs appear 2 cycles after each request in order. eof=1 only with (7,7,1). count=3, err=0.
- After that epoch, pulse rewind, then rd_req. Output is (3,-2,1) with eof=0.
- rewind and rd_req in the same cycle while rd_ptr=2. Output is sample 0.
- DEPTH=16 with 17 writes, wr_last on the 17th. count=16, err=1, state READY. Sample 15 is intact.
- rd_req while EMPTY gives err=1 and valid stays 0. Then clr gives err=0.
- Assert rst during FETCH. All outputs are 0 on the next cycle, ready=0, count=0.

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// Shared types and defaults for the training-sample feeder.
// Stored word layout is {t, x2, x1}, width 2*DW+1.
package sample_feeder_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    FETCH   = 2'd3
  } state_t;

  function automatic int word_w(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/sample_mem.sv
// Simple dual-port sample store: one write port, one registered-read port.
// The array itself carries no reset.
module sample_mem #(
  parameter int W     = 17,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_feeder.sv
// Training-sample source: loads up to DEPTH samples, replays one per rd_req
// with two-cycle latency, flags the last stored sample with eof.
//
// state   | meaning
// EMPTY   | no samples stored
// LOADING | samples arriving, set not yet closed by wr_last
// READY   | set loaded, waiting for rd_req
// FETCH   | memory data arriving, output registers load at end of cycle
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_x1,
  input  logic [DW-1:0] wr_x2,
  input  logic          wr_t,
  input  logic          wr_last,
  input  logic          rewind,
  input  logic          rd_req,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic          t,
  output logic          valid,
  output logic          eof,
  output logic          ready,
  output logic [AW:0]   count,
  output logic          err
);

  localparam int WW = word_w(DW);

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic          mem_we;
  logic          mem_re;
  logic          full;
  logic          fetch_last;

  assign full       = (count == (AW + 1)'(DEPTH));
  assign fetch_last = ((AW + 1)'(fetch_idx) == count - 1'b1);
  assign rd_addr    = rewind ? '0 : rd_ptr;
  assign mem_we     = !clr && wr_en && !full && (state == EMPTY || state == LOADING);
  assign mem_re     = !clr && rd_req && (state == READY);
  assign ready      = (state == READY) || (state == FETCH);

  sample_mem #(.W(WW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (count[AW-1:0]),
    .wdata ({wr_t, wr_x2, wr_x1}),
    .re    (mem_re),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      count     <= '0;
      rd_ptr    <= '0;
      fetch_idx <= '0;
      x1        <= '0;
      x2        <= '0;
      t         <= 1'b0;
      valid     <= 1'b0;
      eof       <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      state     <= EMPTY;
      count     <= '0;
      rd_ptr    <= '0;
      fetch_idx <= '0;
      x1        <= '0;
      x2        <= '0;
      t         <= 1'b0;
      valid     <= 1'b0;
      eof       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (rewind) begin
        rd_ptr <= '0;
        eof    <= 1'b0;
      end
      case (state)
        EMPTY, LOADING: begin
          if (wr_en) begin
            if (full) err <= 1'b1;
            else      count <= count + 1'b1;
            state <= wr_last ? READY : LOADING;
          end
          if (rd_req) err <= 1'b1;
        end
        READY: begin
          if (wr_en) err <= 1'b1;
          if (rd_req) begin
            fetch_idx <= rd_addr;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (wr_en || rd_req) err <= 1'b1;
          state <= READY;
          // a rewind landing on the fetch cycle cancels it; outputs keep their old sample
          if (!rewind) begin
            {t, x2, x1} <= rd_data;
            valid       <= 1'b1;
            eof         <= fetch_last;
            rd_ptr      <= fetch_last ? '0 : fetch_idx + 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// Randomized self-checking bench for sample_feeder against a queue-based model.
module tb_sample_feeder;

  localparam int DW = 8, DEPTH = 16, AW = 4;

  logic clk = 1'b0;
  logic rst, clr, wr_en, wr_t, wr_last, rewind, rd_req;
  logic [DW-1:0] wr_x1, wr_x2, x1, x2;
  logic t, valid, eof, ready, err;
  logic [AW:0] count;

  always #5 clk = ~clk;

  sample_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_x1(wr_x1), .wr_x2(wr_x2),
    .wr_t(wr_t), .wr_last(wr_last), .rewind(rewind), .rd_req(rd_req),
    .x1(x1), .x2(x2), .t(t), .valid(valid), .eof(eof), .ready(ready),
    .count(count), .err(err)
  );

  typedef struct {int x1; int x2; int t;} smp_t;

  int   n_tests = 0, n_fail = 0;
  smp_t q[$];
  smp_t m_out;
  bit   loaded, m_err, m_valid, m_eof;
  int   ptr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void mreset();
    q.delete();
    loaded = 0; m_err = 0; m_valid = 0; m_eof = 0; ptr = 0;
    m_out = '{0, 0, 0};
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".x1"},    int'($signed(x1)), m_out.x1);
    chk({tag, ".x2"},    int'($signed(x2)), m_out.x2);
    chk({tag, ".t"},     int'(t),           m_out.t);
    chk({tag, ".valid"}, int'(valid),       int'(m_valid));
    chk({tag, ".eof"},   int'(eof),         int'(m_eof));
    chk({tag, ".ready"}, int'(ready),       int'(loaded));
    chk({tag, ".count"}, int'(count),       q.size());
    chk({tag, ".err"},   int'(err),         int'(m_err));
  endtask

  task automatic do_write(input int a, input int b, input int tt, input bit last);
    @(negedge clk);
    wr_en = 1; wr_x1 = DW'(a); wr_x2 = DW'(b); wr_t = tt[0]; wr_last = last;
    @(negedge clk);
    wr_en = 0; wr_last = 0;
    if (loaded) m_err = 1;
    else begin
      if (q.size() < DEPTH) q.push_back('{a, b, tt});
      else m_err = 1;
      if (last) loaded = 1;
    end
  endtask

  task automatic do_read(input bit rw, input string tag);
    int idx;
    @(negedge clk);
    rd_req = 1; rewind = rw;
    @(negedge clk);
    rd_req = 0; rewind = 0;
    chk({tag, ".hold_valid"}, int'(valid), int'(m_valid));
    chk({tag, ".hold_x1"}, int'($signed(x1)), m_out.x1);
    if (rw) begin ptr = 0; m_eof = 0; end
    if (!loaded) m_err = 1;
    else begin
      idx     = ptr;
      m_out   = q[idx];
      m_eof   = (idx == q.size() - 1);
      m_valid = 1;
      ptr     = (idx + 1) % q.size();
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    mreset();
  endtask

  task automatic do_rewind();
    @(negedge clk); rewind = 1;
    @(negedge clk); rewind = 0;
    ptr = 0; m_eof = 0;
    compare_all("rewind_only");
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    rst = 1; clr = 0; wr_en = 0; wr_x1 = '0; wr_x2 = '0; wr_t = 0; wr_last = 0;
    rewind = 0; rd_req = 0;
    mreset();
    repeat (3) @(negedge clk);
    rst = 0;
    compare_all("reset");

    // directed epoch
    do_write(3, -2, 1, 0);
    do_write(-5, 4, 0, 0);
    compare_all("loading");
    do_write(7, 7, 1, 1);
    compare_all("loaded");
    for (int i = 0; i < 3; i++) begin
      do_read(0, $sformatf("epoch_rd%0d", i));
      @(negedge clk);
    end
    chk("epoch_last_x1", int'($signed(x1)), 7);
    chk("epoch_last_eof", int'(eof), 1);
    do_read(0, "wrap_rd");
    do_rewind();
    do_read(0, "after_rewind");
    chk("after_rewind_x2", int'($signed(x2)), -2);
    do_read(0, "adv1");
    do_read(1, "rewind_and_req");
    chk("rewind_and_req_x1", int'($signed(x1)), 3);
    do_write(1, 1, 1, 0);
    compare_all("write_in_ready");
    do_clr();
    compare_all("clr");

    // randomized epochs
    for (int ep = 0; ep < 6; ep++) begin
      int n;
      do_clr();
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) begin
        do_write(rnd_s(), rnd_s(), int'($urandom_range(0, 1)), i == n - 1);
        if (ep % 2 == 1 && i == 0 && n > 1) do_read(0, "rd_in_loading");
      end
      compare_all($sformatf("ep%0d_loaded", ep));
      for (int r = 0; r < 2 * n + 1; r++)
        do_read($urandom_range(0, 5) == 0, $sformatf("ep%0d_rd%0d", ep, r));
    end

    // overflow
    do_clr();
    for (int i = 0; i < DEPTH + 1; i++) do_write(rnd_s(), rnd_s(), int'($urandom_range(0, 1)), i == DEPTH);
    compare_all("overflow");
    for (int r = 0; r < DEPTH; r++) do_read(0, $sformatf("ovf_rd%0d", r));
    chk("ovf_eof_at_15", int'(eof), 1);

    // read while empty, then clear
    do_clr();
    do_read(0, "rd_empty");
    do_clr();
    compare_all("clr_after_err");

    // reset in the middle of a fetch
    do_write(10, -10, 1, 0);
    do_write(20, -20, 0, 1);
    do_read(0, "pre_rst");
    @(negedge clk); rd_req = 1;
    @(negedge clk); rd_req = 0;
    #2 rst = 1;
    mreset();
    @(negedge clk);
    compare_all("rst_fetch");
    rst = 0;
    @(negedge clk);
    compare_all("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
